// File: rtl/machine_ctl.sv
// rtl/machine_ctl.sv - 8-step instruction sequencer for the 8-bit RISC core
// Decodes the IR opcode into per-step bus/register strobes and counts retired instructions.
module machine_ctl #(
   parameter int CNT_W       = 16,
   parameter int HALT_STICKY = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             fetch,
   input  logic [2:0]       opcode,
   input  logic             zero,
   output logic             inc_pc,
   output logic             load_acc,
   output logic             load_pc,
   output logic             rd,
   output logic             wr,
   output logic             load_ir,
   output logic             datactl_ena,
   output logic             halt,
   output logic [CNT_W-1:0] instr_cnt
);

   localparam logic [2:0] OP_HLT  = 3'b000;
   localparam logic [2:0] OP_SKZ  = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_ANDD = 3'b011;
   localparam logic [2:0] OP_XORR = 3'b100;
   localparam logic [2:0] OP_LDA  = 3'b101;
   localparam logic [2:0] OP_STO  = 3'b110;
   localparam logic [2:0] OP_JMP  = 3'b111;

   typedef enum logic [2:0] {S0, S1, S2, S3, S4, S5, S6, S7} step_t;

   step_t step;
   step_t n_step;
   logic  ena;
   logic  halted;
   logic  n_inc_pc, n_load_acc, n_load_pc, n_rd, n_wr, n_load_ir, n_datactl_ena, n_halt;
   logic  alu_op;
   logic  skip;

   assign alu_op = (opcode == OP_ADD) || (opcode == OP_ANDD) ||
                   (opcode == OP_XORR) || (opcode == OP_LDA);
   assign skip   = (opcode == OP_SKZ) && zero;

   // Output vector for the step about to execute; registered below.
   always_comb begin
      n_inc_pc      = 1'b0;
      n_load_acc    = 1'b0;
      n_load_pc     = 1'b0;
      n_rd          = 1'b0;
      n_wr          = 1'b0;
      n_load_ir     = 1'b0;
      n_datactl_ena = 1'b0;
      n_halt        = 1'b0;
      n_step        = S0;
      case (step)
         S0: begin
            n_rd      = 1'b1;
            n_load_ir = 1'b1;
            n_step    = S1;
         end
         S1: begin
            n_inc_pc  = 1'b1;
            n_rd      = 1'b1;
            n_load_ir = 1'b1;
            n_step    = S2;
         end
         S2: n_step = S3;
         S3: begin
            n_inc_pc = 1'b1;
            n_halt   = (opcode == OP_HLT);
            n_step   = S4;
         end
         S4: begin
            n_rd          = alu_op;
            n_load_pc     = (opcode == OP_JMP);
            n_datactl_ena = (opcode == OP_STO);
            n_step        = S5;
         end
         S5: begin
            n_rd          = alu_op;
            n_load_acc    = alu_op;
            n_inc_pc      = skip || (opcode == OP_JMP);
            n_load_pc     = (opcode == OP_JMP);
            n_datactl_ena = (opcode == OP_STO);
            n_wr          = (opcode == OP_STO);
            n_step        = S6;
         end
         S6: begin
            n_rd          = alu_op;
            n_datactl_ena = (opcode == OP_STO);
            n_step        = S7;
         end
         S7: begin
            n_inc_pc = skip;
            n_step   = S0;
         end
         default: n_step = S0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ena         <= 1'b0;
         halted      <= 1'b0;
         step        <= S0;
         inc_pc      <= 1'b0;
         load_acc    <= 1'b0;
         load_pc     <= 1'b0;
         rd          <= 1'b0;
         wr          <= 1'b0;
         load_ir     <= 1'b0;
         datactl_ena <= 1'b0;
         halt        <= 1'b0;
         instr_cnt   <= '0;
      end else if (!ena) begin
         ena <= fetch;
      end else if (halted) begin
         inc_pc      <= 1'b0;
         load_acc    <= 1'b0;
         load_pc     <= 1'b0;
         rd          <= 1'b0;
         wr          <= 1'b0;
         load_ir     <= 1'b0;
         datactl_ena <= 1'b0;
         halt        <= 1'b1;
      end else begin
         inc_pc      <= n_inc_pc;
         load_acc    <= n_load_acc;
         load_pc     <= n_load_pc;
         rd          <= n_rd;
         wr          <= n_wr;
         load_ir     <= n_load_ir;
         datactl_ena <= n_datactl_ena;
         halt        <= n_halt;
         step        <= n_step;
         if (step == S7)
            instr_cnt <= instr_cnt + CNT_W'(1);
         if ((HALT_STICKY != 0) && n_halt)
            halted <= 1'b1;
      end
   end

endmodule

// File: tb/tb_machine_ctl.sv
// tb/tb_machine_ctl.sv - directed self-checking bench for machine_ctl
// Sticky-halt DUT with 16-bit counter plus a non-sticky DUT with a 2-bit counter.
module tb_machine_ctl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        fetch = 1'b0;
   logic [2:0]  opcode = 3'b010;
   logic        zero = 1'b0;
   logic        inc_pc, load_acc, load_pc, rd, wr, load_ir, datactl_ena, halt;
   logic [15:0] instr_cnt;
   logic        ns_inc_pc, ns_load_acc, ns_load_pc, ns_rd, ns_wr, ns_load_ir, ns_datactl_ena, ns_halt;
   logic [1:0]  ns_instr_cnt;

   int checks = 0;
   int failures = 0;

   // Bit k of each capture = value of that strobe after the edge executing step k.
   logic [7:0] c_inc, c_acc, c_lpc, c_rd, c_wr, c_ir, c_dat, c_halt, c_nshalt;

   always #5 clk = ~clk;

   machine_ctl #(.CNT_W(16), .HALT_STICKY(1)) dut (
      .clk(clk), .reset(reset), .fetch(fetch), .opcode(opcode), .zero(zero),
      .inc_pc(inc_pc), .load_acc(load_acc), .load_pc(load_pc), .rd(rd), .wr(wr),
      .load_ir(load_ir), .datactl_ena(datactl_ena), .halt(halt), .instr_cnt(instr_cnt)
   );

   machine_ctl #(.CNT_W(2), .HALT_STICKY(0)) dut_ns (
      .clk(clk), .reset(reset), .fetch(fetch), .opcode(opcode), .zero(zero),
      .inc_pc(ns_inc_pc), .load_acc(ns_load_acc), .load_pc(ns_load_pc), .rd(ns_rd), .wr(ns_wr),
      .load_ir(ns_load_ir), .datactl_ena(ns_datactl_ena), .halt(ns_halt), .instr_cnt(ns_instr_cnt)
   );

   task automatic step_clk();
      @(posedge clk);
      #1;
   endtask

   task automatic arm();
      reset = 1'b1;
      fetch = 1'b0;
      #3;
      reset = 1'b0;
      step_clk();
      fetch = 1'b1;
      step_clk();
      fetch = 1'b0;
   endtask

   task automatic run_instr(input logic [2:0] op, input logic z);
      opcode = op;
      zero = z;
      for (int k = 0; k < 8; k++) begin
         step_clk();
         c_inc[k] = inc_pc;      c_acc[k] = load_acc;  c_lpc[k] = load_pc;
         c_rd[k]  = rd;          c_wr[k]  = wr;        c_ir[k]  = load_ir;
         c_dat[k] = datactl_ena; c_halt[k] = halt;     c_nshalt[k] = ns_halt;
      end
   endtask

   task automatic test_reset();
      logic [8:0] any;
      any = '0;
      reset = 1'b1;
      fetch = 1'b0;
      #3;
      reset = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step_clk();
         any = any | {inc_pc, load_acc, load_pc, rd, wr, load_ir, datactl_ena, halt, |instr_cnt};
      end
      checks++;
      if (any !== 9'h0) begin
         failures++;
         $display("FAIL reset_idle outputs_or=%h required=%h", any, 9'h0);
      end
      fetch = 1'b1;
      step_clk();
      fetch = 1'b0;
      checks++;
      if ({rd, load_ir, inc_pc} !== 3'b000) begin
         failures++;
         $display("FAIL arm_edge {rd,load_ir,inc_pc}=%b required=000", {rd, load_ir, inc_pc});
      end
      step_clk();
      checks++;
      if ({rd, load_ir, inc_pc, wr} !== 4'b1100) begin
         failures++;
         $display("FAIL first_step {rd,load_ir,inc_pc,wr}=%b required=1100", {rd, load_ir, inc_pc, wr});
      end
   endtask

   task automatic test_add();
      arm();
      run_instr(3'b010, 1'b0);
      checks++;
      if ({c_rd, c_acc, c_inc, c_ir} !== {8'h73, 8'h20, 8'h0A, 8'h03}) begin
         failures++;
         $display("FAIL add_strobes {rd,acc,inc,ir}=%h required=%h", {c_rd, c_acc, c_inc, c_ir}, {8'h73, 8'h20, 8'h0A, 8'h03});
      end
      checks++;
      if ({c_lpc, c_wr, c_dat, c_halt} !== 32'h0) begin
         failures++;
         $display("FAIL add_idle {lpc,wr,dat,halt}=%h required=0", {c_lpc, c_wr, c_dat, c_halt});
      end
      checks++;
      if (instr_cnt !== 16'd1) begin
         failures++;
         $display("FAIL add_cnt instr_cnt=%0d required=1", instr_cnt);
      end
   endtask

   task automatic test_sto();
      arm();
      run_instr(3'b110, 1'b0);
      checks++;
      if ({c_dat, c_wr, c_rd, c_inc} !== {8'h70, 8'h20, 8'h03, 8'h0A}) begin
         failures++;
         $display("FAIL sto_strobes {dat,wr,rd,inc}=%h required=%h", {c_dat, c_wr, c_rd, c_inc}, {8'h70, 8'h20, 8'h03, 8'h0A});
      end
      checks++;
      if ((c_rd & c_wr) !== 8'h0) begin
         failures++;
         $display("FAIL sto_rd_wr_overlap rd&wr=%h required=00", c_rd & c_wr);
      end
   endtask

   task automatic test_skz();
      arm();
      run_instr(3'b001, 1'b1);
      checks++;
      if (c_inc !== 8'hAA) begin
         failures++;
         $display("FAIL skz_zero1_inc inc=%h required=aa", c_inc);
      end
      run_instr(3'b001, 1'b0);
      checks++;
      if (c_inc !== 8'h0A) begin
         failures++;
         $display("FAIL skz_zero0_inc inc=%h required=0a", c_inc);
      end
      checks++;
      if ({c_rd, c_acc, c_lpc} !== {8'h03, 8'h00, 8'h00}) begin
         failures++;
         $display("FAIL skz_other {rd,acc,lpc}=%h required=030000", {c_rd, c_acc, c_lpc});
      end
   endtask

   task automatic test_jmp();
      arm();
      run_instr(3'b111, 1'b0);
      checks++;
      if ({c_lpc, c_inc, c_rd, c_acc} !== {8'h30, 8'h2A, 8'h03, 8'h00}) begin
         failures++;
         $display("FAIL jmp_strobes {lpc,inc,rd,acc}=%h required=%h", {c_lpc, c_inc, c_rd, c_acc}, {8'h30, 8'h2A, 8'h03, 8'h00});
      end
   endtask

   task automatic test_halt();
      logic [7:0] any;
      logic       all_halt;
      arm();
      run_instr(3'b000, 1'b0);
      checks++;
      if ({c_halt, c_inc, c_rd} !== {8'hF8, 8'h0A, 8'h03}) begin
         failures++;
         $display("FAIL hlt_sticky {halt,inc,rd}=%h required=f80a03", {c_halt, c_inc, c_rd});
      end
      checks++;
      if ((c_nshalt !== 8'h08) || (ns_instr_cnt !== 2'd1)) begin
         failures++;
         $display("FAIL hlt_nonsticky halt=%h cnt=%0d required halt=08 cnt=1", c_nshalt, ns_instr_cnt);
      end
      any = '0;
      all_halt = 1'b1;
      for (int i = 0; i < 32; i++) begin
         opcode = 3'(i);
         zero = i[0];
         step_clk();
         any = any | {inc_pc, load_acc, load_pc, rd, wr, load_ir, datactl_ena, |instr_cnt};
         all_halt = all_halt & halt;
      end
      checks++;
      if ((any !== 8'h0) || (all_halt !== 1'b1)) begin
         failures++;
         $display("FAIL hlt_parked strobes_or=%h halt_all=%b required=00 1", any, all_halt);
      end
      reset = 1'b1;
      #1;
      checks++;
      if (halt !== 1'b0) begin
         failures++;
         $display("FAIL hlt_async_reset halt=%b required=0", halt);
      end
      #2;
      reset = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [7:0] any;
      arm();
      opcode = 3'b010;
      zero = 1'b0;
      for (int k = 0; k < 6; k++) step_clk();
      checks++;
      if (load_acc !== 1'b1) begin
         failures++;
         $display("FAIL mid_pre load_acc=%b required=1", load_acc);
      end
      reset = 1'b1;
      #1;
      checks++;
      if ({load_acc, rd} !== 2'b00) begin
         failures++;
         $display("FAIL mid_async {load_acc,rd}=%b required=00", {load_acc, rd});
      end
      #1;
      reset = 1'b0;
      any = '0;
      for (int i = 0; i < 6; i++) begin
         step_clk();
         any = any | {inc_pc, load_acc, load_pc, rd, wr, load_ir, datactl_ena, halt};
      end
      checks++;
      if (any !== 8'h0) begin
         failures++;
         $display("FAIL mid_wait strobes_or=%h required=00", any);
      end
      fetch = 1'b1;
      step_clk();
      fetch = 1'b0;
      step_clk();
      checks++;
      if ({rd, load_ir, inc_pc, load_acc} !== 4'b1100) begin
         failures++;
         $display("FAIL mid_rearm {rd,load_ir,inc,acc}=%b required=1100", {rd, load_ir, inc_pc, load_acc});
      end
   endtask

   task automatic test_back_to_back();
      arm();
      fetch = 1'b1;
      for (int n = 0; n < 5; n++) run_instr(3'b011, 1'b1);
      fetch = 1'b0;
      checks++;
      if ({c_rd, c_acc, c_inc} !== {8'h73, 8'h20, 8'h0A}) begin
         failures++;
         $display("FAIL b2b_last {rd,acc,inc}=%h required=73200a", {c_rd, c_acc, c_inc});
      end
      checks++;
      if ((instr_cnt !== 16'd5) || (ns_instr_cnt !== 2'd1)) begin
         failures++;
         $display("FAIL b2b_cnt cnt=%0d ns_cnt=%0d required 5 1", instr_cnt, ns_instr_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_sto();
      test_skz();
      test_jmp();
      test_halt();
      test_reset_mid();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout checks=%0d required finish", checks);
      $fatal(1);
   end

endmodule
